// File: rtl/store_decider.sv
// store_decider: read-modify-write sequencer for byte / half-word / word stores.
//
// A store is accepted in IDLE when start is high. Word stores write straight
// through. Byte and half-word stores first read the target word, which takes
// MEM_LATENCY cycles. The low bits of the register value are then merged into
// the old word and the result is written back. The reserved selector finishes
// without touching memory.
//
// Optional feature macro: STORE_ALIGN_CHECK_EN. When it is defined, misaligned
// half-word and word stores are rejected at accept time. They complete with
// done and misaligned pulsing together, and no memory access is made.
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   store request, sampled only in IDLE
//   selector     in   [1:0] 00 byte, 01 half, 10 word, 11 reserved
//   address      in   [31:0] store target address
//   store_data   in   [31:0] register value to store
//   mem_data_in  in   [31:0] memory read data
//   mem_addr     out  [31:0] latched address in READ/WRITE, else 0
//   mem_wr       out  one-cycle write strobe
//   mem_data_out out  [31:0] merged word while mem_wr=1, else 0
//   busy         out  high in every state except IDLE
//   done         out  one-cycle completion pulse
//   misaligned   out  alignment error pulse, coincident with done
module store_decider #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  selector,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_data_out,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  localparam logic [1:0] SEL_BYTE = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b10;
  localparam logic [3:0] LAST_RD  = 4'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] merge_q, merge_d;
`ifdef STORE_ALIGN_CHECK_EN
  logic        mis_q, mis_d;
  logic        align_err;

  assign align_err = ((selector == SEL_HALF) && address[0]) ||
                     ((selector == SEL_WORD) && (address[1:0] != 2'b00));
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      merge_q <= '0;
`ifdef STORE_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      merge_q <= merge_d;
`ifdef STORE_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    merge_d = merge_q;
`ifdef STORE_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d  = selector;
          addr_d = address;
          data_d = store_data;
          cnt_d  = '0;
`ifdef STORE_ALIGN_CHECK_EN
          mis_d  = align_err;
          if (align_err) state_d = DONE;
          else
`endif
          unique case (selector)
            SEL_WORD: begin
              // A full word needs no old data, so the merge register is
              // loaded here and READ is skipped.
              merge_d = store_data;
              state_d = WRITE;
            end
            SEL_BYTE, SEL_HALF: state_d = READ;
            default:            state_d = DONE;
          endcase
        end
      end
      READ: begin
        if (cnt_q == LAST_RD) begin
          // Read data is valid only on the last READ cycle.
          merge_d = (sel_q == SEL_BYTE) ? {mem_data_in[31:8],  data_q[7:0]}
                                        : {mem_data_in[31:16], data_q[15:0]};
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign mem_wr       = (state_q == WRITE);
  assign mem_data_out = mem_wr ? merge_q : '0;
  assign mem_addr     = ((state_q == READ) || (state_q == WRITE)) ? addr_q : '0;
`ifdef STORE_ALIGN_CHECK_EN
  assign misaligned   = done & mis_q;
`else
  assign misaligned   = 1'b0;
`endif

endmodule

// File: tb/tb_store_decider.sv
module tb_store_decider;
  localparam int ML = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  selector = '0;
  logic [31:0] address = '0;
  logic [31:0] store_data = '0;
  logic [31:0] mem_data_in = '0;
  logic [31:0] mem_addr, mem_data_out;
  logic        mem_wr, busy, done, misaligned;

  always #5 clock = ~clock;

  store_decider #(.MEM_LATENCY(ML)) dut (
    .clock(clock), .reset(reset), .start(start), .selector(selector),
    .address(address), .store_data(store_data), .mem_data_in(mem_data_in),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_data_out(mem_data_out),
    .busy(busy), .done(done), .misaligned(misaligned)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic mis; logic [7:0] lat; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  compared = 0, mismatched = 0;
  int  cyc = 0, acc = 0, wr_cnt = 0, done_cnt = 0;
  bit  mon_en = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: pops expected writes / completions as they appear.
  always @(negedge clock) begin
    if (mon_en) begin
      if (mem_wr === 1'b1) begin
        wr_t e;
        wr_cnt++;
        compared++;
        if (wq.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_data_out);
        end else begin
          e = wq.pop_front();
          if ({mem_addr, mem_data_out} !== {e.addr, e.data}) begin
            mismatched++;
            $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                     mem_addr, mem_data_out, e.addr, e.data);
          end
        end
      end else begin
        compared++;
        if (mem_data_out !== 32'h0 || mem_wr !== 1'b0) begin
          mismatched++;
          $display("FAIL idle_data: got wr=%b data=%h, required wr=0 data=0", mem_wr, mem_data_out);
        end
      end
      if (busy === 1'b0) begin
        compared++;
        if (mem_addr !== 32'h0) begin
          mismatched++;
          $display("FAIL idle_addr: got %h, required 0", mem_addr);
        end
      end
      if (done === 1'b1) begin
        dn_t e;
        done_cnt++;
        compared++;
        if (dq.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_done: got done=1, required 0");
        end else begin
          e = dq.pop_front();
          if ({misaligned, 8'(cyc - acc + 1)} !== {e.mis, e.lat}) begin
            mismatched++;
            $display("FAIL done: got mis=%b lat=%0d, required mis=%b lat=%0d",
                     misaligned, cyc - acc + 1, e.mis, e.lat);
          end
        end
      end else begin
        compared++;
        if (misaligned !== 1'b0 || done !== 1'b0) begin
          mismatched++;
          $display("FAIL stray_pulse: got done=%b mis=%b, required 0/0", done, misaligned);
        end
      end
    end
  end

  // Drive one store and push its expected outcome to the scoreboard.
  task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    logic mis;
    wr_t  w;
    dn_t  n;
`ifdef STORE_ALIGN_CHECK_EN
    mis = ((s == 2'b01) && a[0]) || ((s == 2'b10) && (a[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    @(posedge clock); #2;
    selector = s; address = a; store_data = d; start = 1'b1;
    acc = cyc + 1;
    w.addr = a;
    n.mis  = mis;
    if (mis || s == 2'b11) begin
      n.lat = 8'd1;
    end else if (s == 2'b10) begin
      w.data = d;
      n.lat  = 8'd2;
      wq.push_back(w);
    end else begin
      w.data = (s == 2'b00) ? {mem_data_in[31:8], d[7:0]} : {mem_data_in[31:16], d[15:0]};
      n.lat  = 8'(ML + 2);
      wq.push_back(w);
    end
    dq.push_back(n);
    @(posedge clock); #2;
    // Later input changes must not affect the accepted store.
    start = 1'b0; selector = 2'($urandom); address = $urandom; store_data = $urandom;
  endtask

  task automatic wait_done(input string nm);
    int base = done_cnt;
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); #1;
      if (done_cnt != base) begin ok = 1; break; end
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s_timeout: got no done, required done within 40 cycles", nm);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; selector = 2'b10; address = 32'h40; store_data = 32'h1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    compared++;
    if ({mem_addr, mem_wr, mem_data_out, busy, done, misaligned} !== 68'h0) begin
      mismatched++;
      $display("FAIL reset: got addr=%h wr=%b data=%h busy=%b done=%b mis=%b, required all 0",
               mem_addr, mem_wr, mem_data_out, busy, done, misaligned);
    end
    @(posedge clock); #2;
    reset = 1'b0; start = 1'b0;
    mon_en = 1;
  endtask

  task automatic test_word();
    issue(2'b10, 32'h40, 32'hDEADBEEF);
    wait_done("word");
  endtask

  task automatic test_byte_half();
    mem_data_in = 32'h11223344;
    issue(2'b00, 32'h100, 32'hAABBCCDD);
    wait_done("byte");
    issue(2'b01, 32'h102, 32'h0000BEEF);
    wait_done("half");
    mem_data_in = 32'hCAFEF00D;
    issue(2'b00, 32'h103, 32'h00000080);
    wait_done("byte_high_bit");
  endtask

  task automatic test_reserved();
    issue(2'b11, 32'h80, 32'h12345678);
    wait_done("reserved");
  endtask

  task automatic test_misaligned();
    issue(2'b10, 32'h42, 32'h55AA55AA);
    wait_done("mis_word");
    mem_data_in = 32'h11223344;
    issue(2'b01, 32'h41, 32'h0000BEEF);
    wait_done("mis_half");
    issue(2'b00, 32'h43, 32'h000000EE);
    wait_done("byte_any_addr");
  endtask

  task automatic test_back_to_back();
    mem_data_in = 32'h89ABCDEF;
    issue(2'b10, 32'h500, 32'h01020304);
    wait_done("b2b_1");
    issue(2'b00, 32'h504, 32'hFFFFFF11);
    wait_done("b2b_2");
    issue(2'b11, 32'h508, 32'h0);
    wait_done("b2b_3");
  endtask

  task automatic test_busy_start();
    int w0, d0;
    mem_data_in = 32'h11223344;
    w0 = wr_cnt; d0 = done_cnt;
    issue(2'b00, 32'h200, 32'h12345678);
    start = 1'b1; selector = 2'b10; address = 32'h300; store_data = 32'hBADBAD00;
    @(posedge clock); #2;
    start = 1'b0;
    wait_done("busy");
    repeat (4) @(negedge clock);
    compared++;
    if ((wr_cnt - w0) != 1 || (done_cnt - d0) != 1) begin
      mismatched++;
      $display("FAIL busy_start: got writes=%0d dones=%0d, required 1/1", wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    mem_data_in = 32'h11223344;
    w0 = wr_cnt;
    issue(2'b00, 32'h300, 32'hAABBCCDD);  // now in the first READ cycle
    wq.delete(); dq.delete();
    @(posedge clock); #2;                  // second READ cycle
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    compared++;
    if ({mem_addr, mem_wr, mem_data_out, busy, done, misaligned} !== 68'h0) begin
      mismatched++;
      $display("FAIL reset_mid: got addr=%h wr=%b data=%h busy=%b done=%b mis=%b, required all 0",
               mem_addr, mem_wr, mem_data_out, busy, done, misaligned);
    end
    @(posedge clock); #2;
    reset = 1'b0;
    repeat (8) @(negedge clock);
    compared++;
    if (wr_cnt != w0) begin
      mismatched++;
      $display("FAIL reset_abort: got %0d writes, required 0", wr_cnt - w0);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_reserved();
    test_misaligned();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    test_word();
    repeat (3) @(negedge clock);
    compared++;
    if (wq.size() != 0 || dq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d writes %0d dones pending, required 0/0", wq.size(), dq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
